cdr_trigger_sequencer: RTL and testbench
========================================

Name: cdr_trigger_sequencer

Overview:
Arm/fire/holdoff controller for the CDR trigger datapath, in the rx_clk domain.
- Selects 8B/10B or 64B/66B as the trigger source.
- Qualifies the selected symbol lock for a programmable time before arming.
- Converts the selected engine's raw match into a single registered trigger pulse, then applies holdoff or single-shot policy.
- Config inputs come from the APB register block, already synchronized to clk.

Parameters:
HOLDOFF_BITS, 16, width of holdoff cycle count
QUAL_BITS, 12, width of lock-qualification cycle count
COUNT_BITS, 32, width of trigger event counter

Ports:
clk  input  1  rx_clk-domain clock
rst_n  input  1  synchronous active-low reset
arm  input  1  pulse: start arm sequence (honoured only in IDLE)
disarm  input  1  pulse: abort to IDLE from any state
cfg_mode  input  1  0=8B/10B, 1=64B/66B; sampled on accepted arm
cfg_single  input  1  1=single-shot, 0=auto-rearm; sampled on accepted arm
cfg_holdoff  input  HOLDOFF_BITS  post-trigger dead time in cycles
cfg_qual  input  QUAL_BITS  cycles lock must hold before ARMED
lock_8b10b  input  1  8B/10B all-lanes-locked
lock_64b66b  input  1  64B/66B block sync good
match_8b10b  input  1  raw pattern-match strobe, 8B/10B engine
match_64b66b  input  1  raw pattern-match strobe, 64B/66B engine
force_trig  input  1  software trigger pulse
trig_out  output  1  registered one-cycle trigger pulse
armed  output  1  high in ARMED state only
state  output  3  current state encoding (status readback)
engine_rst  output  1  holds match engines in reset; low only in ARMED/HOLDOFF
lock_lost  output  1  sticky: lock dropped while ARMED/HOLDOFF; cleared on accepted arm
trig_count  output  COUNT_BITS  saturating count of fired triggers

Behaviour:
Reset values:
- state=IDLE; trig_out=0; armed=0; engine_rst=1; lock_lost=0; trig_count=0.
- Registered mode/single copies are 0.

Source selection: lock_sel, match_sel and the QUAL/HOLDOFF counter values use the mode_q captured at arm. cfg_mode changes while not IDLE have no effect.

Priority each cycle: disarm > lock loss > match/force > counter expiry.

IDLE:
- arm & !disarm -> WAIT_LOCK.
- Capture mode_q and single_q; clear lock_lost.

WAIT_LOCK:
- lock_sel=1 and cfg_qual=0 -> ARMED.
- lock_sel=1 and cfg_qual!=0 -> QUALIFY, counter loaded with cfg_qual.

QUALIFY:
- Counter decrements while lock_sel=1.
- lock_sel=0 -> WAIT_LOCK.
- ARMED is entered exactly cfg_qual cycles after QUALIFY entry.

ARMED:
- lock_sel=0 -> lock_lost=1, go to WAIT_LOCK, no trigger.
- Otherwise match_sel|force_trig -> trig_out=1 next cycle; trig_count+1 (holds at all-ones).
- Then go to IDLE if single_q, else to HOLDOFF with counter=cfg_holdoff.

HOLDOFF:
- match and force are ignored.
- Duration is max(cfg_holdoff,1) cycles, then -> ARMED.
- lock_sel=0 at any point -> lock_lost=1, go to WAIT_LOCK.

force_trig outside ARMED: ignored. It never bypasses lock qualification.

Timing and pulse rules:
- Latency is fixed: match at edge N -> trig_out high for cycle N+1 only.
- Back-to-back matches during the trigger cycle fall into HOLDOFF and are dropped.
- A single-shot trigger is followed by IDLE.

Other boundary rules:
- disarm: next state IDLE from any state; the trigger is suppressed even if a match arrives the same cycle.
- arm+disarm in the same cycle: disarm wins.
- arm outside IDLE: ignored.
- Reset mid-operation returns all outputs to reset values at the next edge; trig_count is cleared.

Decomposition:
- Package cdr_trig_pkg: state enum (IDLE=0, WAIT_LOCK=1, QUALIFY=2, ARMED=3, HOLDOFF=4) and mode enum (MODE_8B10B=0, MODE_64B66B=1).
- The APB block also imports the package for status decode.
- No sub-module: one shared down-counter sized max(HOLDOFF_BITS,QUAL_BITS), inline with the FSM.

Test Plan:
1. Reset, cfg_mode=1, cfg_qual=5, lock_64b66b=1, arm pulse -> WAIT_LOCK, then QUALIFY, ARMED exactly 5 cycles later; armed=1, engine_rst=0.
2. ARMED, single=0, cfg_holdoff=10, match_64b66b every cycle for 30 cycles -> trig_out pulses 11 cycles apart (1 trigger cycle + 10 holdoff); trig_count=3; each pulse 1 cycle after its match.
3. QUALIFY with cfg_qual=100, lock drops at count 50 -> back to WAIT_LOCK; relock -> full 100 cycles before ARMED; lock_lost stays 0.
4. ARMED, lock_64b66b falls -> lock_lost=1, WAIT_LOCK, no trig_out; the following arm clears lock_lost.
5. Armed in mode 0, cfg_mode flipped to 1, match_64b66b pulsed -> no trigger; match_8b10b -> trigger; arm+disarm same cycle in IDLE -> stays IDLE.
6. COUNT_BITS=4, 20 triggers in auto-rearm -> trig_count saturates at 15; cfg_holdoff=0 gives HOLDOFF of 1 cycle; rst_n low mid-HOLDOFF -> all outputs at reset values next edge.

Source files
------------

// File: rtl/cdr_trig_pkg.sv
// Shared state and mode encodings for the CDR trigger sequencer and its APB status decode.
package cdr_trig_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOCK = 3'd1,
        QUALIFY   = 3'd2,
        ARMED     = 3'd3,
        HOLDOFF   = 3'd4
    } state_t;

    typedef enum logic {
        MODE_8B10B  = 1'b0,
        MODE_64B66B = 1'b1
    } mode_t;

endpackage

// File: rtl/cdr_trigger_sequencer.sv
// Arm/qualify/fire/holdoff controller for the CDR trigger datapath (rx_clk domain).
module cdr_trigger_sequencer
    import cdr_trig_pkg::*;
#(
    parameter int HOLDOFF_BITS = 16,
    parameter int QUAL_BITS    = 12,
    parameter int COUNT_BITS   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    arm,
    input  logic                    disarm,
    input  logic                    cfg_mode,
    input  logic                    cfg_single,
    input  logic [HOLDOFF_BITS-1:0] cfg_holdoff,
    input  logic [QUAL_BITS-1:0]    cfg_qual,
    input  logic                    lock_8b10b,
    input  logic                    lock_64b66b,
    input  logic                    match_8b10b,
    input  logic                    match_64b66b,
    input  logic                    force_trig,
    output logic                    trig_out,
    output logic                    armed,
    output logic [2:0]              state,
    output logic                    engine_rst,
    output logic                    lock_lost,
    output logic [COUNT_BITS-1:0]   trig_count
);

    localparam int CNT_W = (HOLDOFF_BITS > QUAL_BITS) ? HOLDOFF_BITS : QUAL_BITS;

    state_t           state_q;
    state_t           state_d;
    mode_t            mode_q;
    logic             single_q;
    logic [CNT_W-1:0] cnt_q;
    logic             lock_sel;
    logic             match_sel;
    logic             cnt_last;
    logic             fire;
    logic             arm_ok;

    assign lock_sel  = (mode_q == MODE_64B66B) ? lock_64b66b  : lock_8b10b;
    assign match_sel = (mode_q == MODE_64B66B) ? match_64b66b : match_8b10b;
    assign cnt_last  = (cnt_q <= CNT_W'(1));
    assign arm_ok    = (state_q == IDLE) && arm && !disarm;
    assign fire      = (state_q == ARMED) && !disarm && lock_sel && (match_sel || force_trig);
    assign state     = state_q;

    always_comb begin
        state_d = state_q;
        if (disarm) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      if (arm) state_d = WAIT_LOCK;
                WAIT_LOCK: if (lock_sel) state_d = (cfg_qual == '0) ? ARMED : QUALIFY;
                QUALIFY: begin
                    if (!lock_sel)     state_d = WAIT_LOCK;
                    else if (cnt_last) state_d = ARMED;
                end
                ARMED: begin
                    if (!lock_sel)                       state_d = WAIT_LOCK;
                    else if (match_sel || force_trig)    state_d = single_q ? IDLE : HOLDOFF;
                end
                HOLDOFF: begin
                    if (!lock_sel)     state_d = WAIT_LOCK;
                    else if (cnt_last) state_d = ARMED;
                end
                default:   state_d = IDLE;
            endcase
        end
    end

    // The shared counter is preloaded one state early (in WAIT_LOCK / ARMED) so the
    // QUALIFY and HOLDOFF durations count from their first cycle; a load of 0 or 1 both last one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= MODE_8B10B;
            single_q   <= 1'b0;
            cnt_q      <= '0;
            trig_out   <= 1'b0;
            armed      <= 1'b0;
            engine_rst <= 1'b1;
            lock_lost  <= 1'b0;
            trig_count <= '0;
        end else begin
            state_q    <= state_d;
            trig_out   <= fire;
            armed      <= (state_d == ARMED);
            engine_rst <= !((state_d == ARMED) || (state_d == HOLDOFF));

            if (arm_ok) begin
                mode_q    <= mode_t'(cfg_mode);
                single_q  <= cfg_single;
                lock_lost <= 1'b0;
            end
            if (((state_q == ARMED) || (state_q == HOLDOFF)) && !disarm && !lock_sel)
                lock_lost <= 1'b1;

            if (fire && (trig_count != '1))
                trig_count <= trig_count + COUNT_BITS'(1);

            case (state_q)
                WAIT_LOCK:        cnt_q <= CNT_W'(cfg_qual);
                ARMED:            cnt_q <= CNT_W'(cfg_holdoff);
                QUALIFY, HOLDOFF: if (lock_sel && !cnt_last) cnt_q <= cnt_q - CNT_W'(1);
                default:          ;
            endcase
        end
    end

endmodule

// File: tb/tb_cdr_trigger_sequencer.sv
// Bench for cdr_trigger_sequencer: directed scenarios plus random traffic against a phase/elapsed-time model.
module tb_cdr_trigger_sequencer;

    localparam int HB = 16;
    localparam int QB = 12;
    localparam int CB = 4;
    localparam int CNT_MAX = (1 << CB) - 1;

    localparam int P_IDLE = 0, P_WAIT = 1, P_QUAL = 2, P_ARMED = 3, P_HOLD = 4;

    logic          clk = 1'b0;
    logic          rst_n, arm, disarm, cfg_mode, cfg_single;
    logic [HB-1:0] cfg_holdoff;
    logic [QB-1:0] cfg_qual;
    logic          lock_8b10b, lock_64b66b, match_8b10b, match_64b66b, force_trig;
    logic          trig_out, armed, engine_rst, lock_lost;
    logic [2:0]    state;
    logic [CB-1:0] trig_count;

    int checks = 0;
    int failures = 0;

    // reference model
    int m_phase, m_elapsed, m_target, m_count;
    bit m_mode, m_single, m_lock_lost, m_trig;

    cdr_trigger_sequencer #(
        .HOLDOFF_BITS(HB),
        .QUAL_BITS   (QB),
        .COUNT_BITS  (CB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .disarm(disarm),
        .cfg_mode(cfg_mode), .cfg_single(cfg_single),
        .cfg_holdoff(cfg_holdoff), .cfg_qual(cfg_qual),
        .lock_8b10b(lock_8b10b), .lock_64b66b(lock_64b66b),
        .match_8b10b(match_8b10b), .match_64b66b(match_64b66b),
        .force_trig(force_trig),
        .trig_out(trig_out), .armed(armed), .state(state),
        .engine_rst(engine_rst), .lock_lost(lock_lost), .trig_count(trig_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Rules applied per clock edge, using the inputs that were stable before it.
    task automatic model_step();
        bit lk, mt;
        lk = m_mode ? lock_64b66b : lock_8b10b;
        mt = m_mode ? match_64b66b : match_8b10b;
        m_trig = 0;
        if (!rst_n) begin
            m_phase = P_IDLE; m_mode = 0; m_single = 0; m_lock_lost = 0; m_count = 0;
        end else if (disarm) begin
            m_phase = P_IDLE;
        end else if (m_phase == P_IDLE) begin
            if (arm) begin
                m_phase = P_WAIT; m_mode = cfg_mode; m_single = cfg_single; m_lock_lost = 0;
            end
        end else if (m_phase == P_WAIT) begin
            if (lk) begin
                m_elapsed = 0;
                m_target  = int'(cfg_qual);
                m_phase   = (m_target == 0) ? P_ARMED : P_QUAL;
            end
        end else if (!lk) begin
            if (m_phase != P_QUAL) m_lock_lost = 1;
            m_phase = P_WAIT;
        end else if (m_phase == P_ARMED) begin
            if (mt || force_trig) begin
                m_trig = 1;
                if (m_count < CNT_MAX) m_count++;
                m_elapsed = 0;
                m_target  = (cfg_holdoff == 0) ? 1 : int'(cfg_holdoff);
                m_phase   = m_single ? P_IDLE : P_HOLD;
            end
        end else begin
            m_elapsed++;
            if (m_elapsed == m_target) m_phase = P_ARMED;
        end
    endtask

    task automatic compare_all();
        check("state", 32'(state), 32'(m_phase));
        check("trig_out", 32'(trig_out), 32'(m_trig));
        check("armed", 32'(armed), 32'(m_phase == P_ARMED));
        check("engine_rst", 32'(engine_rst), 32'(!(m_phase == P_ARMED || m_phase == P_HOLD)));
        check("lock_lost", 32'(lock_lost), 32'(m_lock_lost));
        check("trig_count", 32'(trig_count), 32'(m_count));
    endtask

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
            compare_all();
            @(negedge clk);
        end
    endtask

    task automatic pulse_arm();
        arm = 1; cycle(1); arm = 0;
    endtask

    initial begin
        rst_n = 0; arm = 0; disarm = 0; cfg_mode = 0; cfg_single = 0;
        cfg_holdoff = 16'd10; cfg_qual = 12'd5;
        lock_8b10b = 0; lock_64b66b = 0; match_8b10b = 0; match_64b66b = 0; force_trig = 0;
        m_phase = P_IDLE; m_elapsed = 0; m_target = 0; m_count = 0;
        m_mode = 0; m_single = 0; m_lock_lost = 0; m_trig = 0;
        @(negedge clk);
        cycle(2);
        check("rst_engine_rst", 32'(engine_rst), 32'd1);
        check("rst_state", 32'(state), 32'd0);
        rst_n = 1;

        // 64B/66B lock with 5-cycle qualification, then auto-rearm holdoff of 10
        cfg_mode = 1; lock_64b66b = 1;
        pulse_arm();
        check("t1_wait", 32'(state), 32'd1);
        cycle(1);
        check("t1_qual", 32'(state), 32'd2);
        cycle(4);
        check("t1_not_yet", 32'(armed), 32'd0);
        cycle(1);
        check("t1_armed", 32'(armed), 32'd1);
        check("t1_eng", 32'(engine_rst), 32'd0);
        match_64b66b = 1; cycle(30); match_64b66b = 0;
        check("t2_count", 32'(trig_count), 32'd3);
        cycle(12);

        // qualification interrupted half-way restarts from scratch
        disarm = 1; cycle(1); disarm = 0;
        cfg_qual = 12'd100;
        pulse_arm();
        cycle(51);
        lock_64b66b = 0; cycle(3);
        check("t3_back_wait", 32'(state), 32'd1);
        lock_64b66b = 1; cycle(100);
        check("t3_not_yet", 32'(armed), 32'd0);
        cycle(1);
        check("t3_armed", 32'(armed), 32'd1);
        check("t3_no_lost", 32'(lock_lost), 32'd0);

        // lock loss while armed, cleared by the next arm
        lock_64b66b = 0; match_64b66b = 1; cycle(1); match_64b66b = 0;
        check("t4_lost", 32'(lock_lost), 32'd1);
        check("t4_no_trig", 32'(trig_out), 32'd0);
        disarm = 1; cycle(1); disarm = 0;
        cfg_qual = 12'd0; lock_64b66b = 1;
        pulse_arm();
        check("t4_cleared", 32'(lock_lost), 32'd0);

        // mode captured at arm; live cfg_mode changes are ignored
        disarm = 1; cycle(1); disarm = 0;
        cfg_mode = 0; cfg_single = 1; lock_8b10b = 1; lock_64b66b = 0;
        pulse_arm(); cycle(1);
        cfg_mode = 1;
        match_64b66b = 1; cycle(1); match_64b66b = 0;
        check("t5_no_trig", 32'(trig_out), 32'd0);
        match_8b10b = 1; cycle(1); match_8b10b = 0;
        check("t5_trig", 32'(trig_out), 32'd1);
        check("t5_single_idle", 32'(state), 32'd0);
        arm = 1; disarm = 1; cycle(1); arm = 0; disarm = 0;
        check("t5_armdisarm", 32'(state), 32'd0);

        // saturation with zero holdoff, then reset in the middle of holdoff
        cfg_mode = 0; cfg_single = 0; cfg_holdoff = 16'd0;
        pulse_arm(); cycle(1);
        match_8b10b = 1; cycle(45); match_8b10b = 0;
        check("t6_sat", 32'(trig_count), 32'd15);
        cfg_holdoff = 16'd6; force_trig = 1; cycle(2); force_trig = 0;
        cycle(1);
        check("t6_in_hold", 32'(state), 32'd4);
        rst_n = 0; cycle(1); rst_n = 1;
        check("t6_rst_count", 32'(trig_count), 32'd0);
        check("t6_rst_eng", 32'(engine_rst), 32'd1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n        = ($urandom_range(0, 399) != 0);
            arm          = ($urandom_range(0, 7) == 0);
            disarm       = ($urandom_range(0, 59) == 0);
            cfg_mode     = 1'($urandom);
            cfg_single   = ($urandom_range(0, 3) == 0);
            cfg_qual     = 12'($urandom_range(0, 8));
            cfg_holdoff  = 16'($urandom_range(0, 6));
            lock_8b10b   = ($urandom_range(0, 29) != 0);
            lock_64b66b  = ($urandom_range(0, 29) != 0);
            match_8b10b  = ($urandom_range(0, 2) == 0);
            match_64b66b = ($urandom_range(0, 2) == 0);
            force_trig   = ($urandom_range(0, 15) == 0);
            cycle(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
